hand_locate: RTL and testbench

- Upstream of the VGA overlay stage.
- Consumes the per-pixel binarised skin mask together with the LCD scan coordinates.
- Accumulates count, coordinate sums and min/max extents of skin pixels inside the detection window over each frame.
- At frame end, computes the centroid by sequential division and publishes centre_x/centre_y plus the bounding box (x/y_min/max_locate) for the overlay to draw.

---
 rtl/hand_locate_pkg.sv | 28 ++
 rtl/hand_locate_if.sv | 31 +++
 rtl/hand_locate_seq_divider.sv | 65 ++++++
 rtl/hand_locate.sv | 215 +++++++++++++++++++++
 tb/tb_hand_locate.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hand_locate_pkg.sv
// Shared types and constants for the hand_locate centroid/bounding-box block.
package hand_locate_pkg;

  localparam int CNT_W      = 18;
  localparam int SUM_W      = 27;
  localparam int COORD_W    = 10;
  localparam int DIV_CYCLES = 27;

  typedef enum logic [1:0] {
    ACCUM,
    SNAP,
    DIV,
    UPDATE
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;

  // (3*old + new) >> 2 evaluated at 12 bits; an off-panel previous value is replaced outright.
  function automatic coord_t smooth(coord_t old_v, coord_t new_v, coord_t no_hand);
    logic [11:0] acc;
    if (old_v == no_hand) begin
      return new_v;
    end
    acc = 12'(old_v) * 12'd3 + 12'(new_v);
    return acc[11:2];
  endfunction

endpackage

// File: rtl/hand_locate_if.sv
// Pixel-stream inputs and published overlay coordinates of hand_locate.
interface hand_locate_if;
  import hand_locate_pkg::*;

  logic        pix_valid;
  logic [11:0] lcd_x;
  logic [11:0] lcd_y;
  logic        pix_bin;
  logic        vsync;
  coord_t      centre_x;
  coord_t      centre_y;
  coord_t      x_min_locate;
  coord_t      x_max_locate;
  coord_t      y_min_locate;
  coord_t      y_max_locate;
  logic        result_valid;
  logic        overrun;

  modport master (
    output pix_valid, lcd_x, lcd_y, pix_bin, vsync,
    input  centre_x, centre_y, x_min_locate, x_max_locate,
           y_min_locate, y_max_locate, result_valid, overrun
  );

  modport slave (
    input  pix_valid, lcd_x, lcd_y, pix_bin, vsync,
    output centre_x, centre_y, x_min_locate, x_max_locate,
           y_min_locate, y_max_locate, result_valid, overrun
  );

endinterface

// File: rtl/hand_locate_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done pulses once after DIV_CYCLES steps.
module seq_divider
  import hand_locate_pkg::*;
#(
  parameter int OUT_W = COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [OUT_W-1:0] quotient,
  output logic             done
);

  logic [SUM_W-1:0] quo_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] dvs_reg;
  logic [4:0]       iter_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W:0]   trial;
  logic             fits;

  // The dividend shifts out of quo_reg while quotient bits shift in behind it.
  always_comb begin
    trial = {rem_reg, quo_reg[SUM_W-1]};
    fits  = (trial >= {1'b0, dvs_reg});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg  <= '0;
      rem_reg  <= '0;
      dvs_reg  <= '0;
      iter_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        busy_reg <= 1'b0;
      end else if (start) begin
        quo_reg  <= dividend;
        rem_reg  <= '0;
        dvs_reg  <= divisor;
        iter_reg <= '0;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg  <= fits ? CNT_W'(trial - {1'b0, dvs_reg}) : trial[CNT_W-1:0];
        quo_reg  <= {quo_reg[SUM_W-2:0], fits};
        iter_reg <= iter_reg + 5'd1;
        if (iter_reg == 5'(DIV_CYCLES - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg[OUT_W-1:0];
  assign done     = done_reg;

endmodule

// File: rtl/hand_locate.sv
// Per-frame skin-pixel centroid and bounding box for the VGA overlay.
// Optional HAND_LOCATE_SMOOTH_EN low-pass filters the published coordinates across frames.
module hand_locate
  import hand_locate_pkg::*;
#(
  parameter int     X_MIN      = 100,
  parameter int     X_MAX      = 500,
  parameter int     Y_MIN      = 0,
  parameter int     Y_MAX      = 400,
  parameter int     MIN_PIXELS = 256,
  parameter coord_t NO_HAND    = 10'd1023
) (
  input logic          clk,
  input logic          rst_n,
  hand_locate_if.slave bus
);

  localparam logic signed [12:0] X_LO = 13'(X_MIN);
  localparam logic signed [12:0] X_HI = 13'(X_MAX);
  localparam logic signed [12:0] Y_LO = 13'(Y_MIN);
  localparam logic signed [12:0] Y_HI = 13'(Y_MAX);

  generate
    if (MIN_PIXELS < 1) begin : g_bad_min_pixels
      $error("hand_locate: MIN_PIXELS must be at least 1");
    end
  endgenerate

  logic             pix_valid_reg;
  logic             pix_bin_reg;
  logic             vsync_reg;
  logic             vsync_d_reg;
  logic [11:0]      x_reg;
  logic [11:0]      y_reg;
  logic signed [12:0] x_s;
  logic signed [12:0] y_s;
  logic             frame_end;
  logic             hit;
  logic             cnt_ok;
  logic             div_start;
  logic             div_abort;
  logic             hand_ok;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       div_cnt_reg;
  state_t           state_reg;
  coord_t           coord    [2];
  coord_t           quo      [2];
  coord_t           min_snap [2];
  coord_t           max_snap [2];
  logic             done     [2];
  coord_t           new_val  [6];
  coord_t           out_reg  [6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_reg <= 1'b0;
      pix_bin_reg   <= 1'b0;
      vsync_reg     <= 1'b0;
      vsync_d_reg   <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
    end else begin
      pix_valid_reg <= bus.pix_valid;
      pix_bin_reg   <= bus.pix_bin;
      vsync_reg     <= bus.vsync;
      vsync_d_reg   <= vsync_reg;
      x_reg         <= bus.lcd_x;
      y_reg         <= bus.lcd_y;
    end
  end

  assign x_s       = $signed({1'b0, x_reg});
  assign y_s       = $signed({1'b0, y_reg});
  assign frame_end = vsync_reg & ~vsync_d_reg;
  assign hit       = pix_valid_reg & pix_bin_reg &
                     (x_s >= X_LO) & (x_s <= X_HI) &
                     (y_s >= Y_LO) & (y_s <= Y_HI);
  assign coord[0]  = x_reg[COORD_W-1:0];
  assign coord[1]  = y_reg[COORD_W-1:0];

  assign cnt_ok    = (cnt_reg >= CNT_W'(MIN_PIXELS));
  assign div_start = (state_reg == SNAP) & cnt_ok;
  assign div_abort = (state_reg == SNAP) & ~cnt_ok;

  // In SNAP the live count restarts, so a hit landing in that cycle belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == SNAP) begin
      cnt_reg <= hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic [SUM_W-1:0] sum_reg;
      coord_t           min_reg;
      coord_t           max_reg;
      coord_t           min_snap_reg;
      coord_t           max_snap_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_reg      <= '0;
          min_reg      <= '1;
          max_reg      <= '0;
          min_snap_reg <= '1;
          max_snap_reg <= '0;
        end else if (state_reg == SNAP) begin
          min_snap_reg <= min_reg;
          max_snap_reg <= max_reg;
          sum_reg      <= hit ? SUM_W'(coord[gi]) : '0;
          min_reg      <= hit ? coord[gi] : '1;
          max_reg      <= hit ? coord[gi] : '0;
        end else if (hit) begin
          sum_reg <= sum_reg + SUM_W'(coord[gi]);
          if (coord[gi] < min_reg) begin
            min_reg <= coord[gi];
          end
          if (coord[gi] > max_reg) begin
            max_reg <= coord[gi];
          end
        end
      end

      assign min_snap[gi] = min_snap_reg;
      assign max_snap[gi] = max_snap_reg;

      // Loads straight from the live accumulators in SNAP; they hold the same values the shadows take.
      seq_divider #(.OUT_W(COORD_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (sum_reg),
        .divisor  (cnt_reg),
        .quotient (quo[gi]),
        .done     (done[gi])
      );
    end
  endgenerate

  assign new_val[0] = quo[0];
  assign new_val[1] = quo[1];
  assign new_val[2] = min_snap[0];
  assign new_val[3] = max_snap[0];
  assign new_val[4] = min_snap[1];
  assign new_val[5] = max_snap[1];

  // Divider done in UPDATE means a full-count frame; a skipped or aborted divide leaves it low.
  assign hand_ok = done[0] & done[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ACCUM;
      div_cnt_reg      <= '0;
      bus.result_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        out_reg[i] <= NO_HAND;
      end
    end else begin
      bus.result_valid <= 1'b0;
      case (state_reg)
        ACCUM: begin
          if (frame_end) begin
            state_reg <= SNAP;
          end
        end
        SNAP: begin
          div_cnt_reg <= '0;
          state_reg   <= cnt_ok ? DIV : UPDATE;
        end
        DIV: begin
          if (frame_end) begin
            bus.overrun <= 1'b1;
            state_reg   <= SNAP;
          end else begin
            div_cnt_reg <= div_cnt_reg + 5'd1;
            if (div_cnt_reg == 5'(DIV_CYCLES - 1)) begin
              state_reg <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (frame_end) begin
            bus.overrun <= 1'b1;
            state_reg   <= SNAP;
          end else begin
            state_reg        <= ACCUM;
            bus.result_valid <= 1'b1;
            for (int i = 0; i < 6; i++) begin
`ifdef HAND_LOCATE_SMOOTH_EN
              out_reg[i] <= hand_ok ? smooth(out_reg[i], new_val[i], NO_HAND) : NO_HAND;
`else
              out_reg[i] <= hand_ok ? new_val[i] : NO_HAND;
`endif
            end
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign bus.centre_x     = out_reg[0];
  assign bus.centre_y     = out_reg[1];
  assign bus.x_min_locate = out_reg[2];
  assign bus.x_max_locate = out_reg[3];
  assign bus.y_min_locate = out_reg[4];
  assign bus.y_max_locate = out_reg[5];

endmodule

// File: tb/tb_hand_locate.sv
// Self-checking bench for hand_locate: directed frames plus random pixel frames against a frame-level model.
module tb_hand_locate;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hand_locate_if bus ();

  hand_locate dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Frame-level reference: plain integer statistics of the pixels that satisfy the hit rule.
  int m_cnt, m_sx, m_sy, m_xmin, m_xmax, m_ymin, m_ymax;
  int exp_out [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_new_frame();
    m_cnt  = 0;
    m_sx   = 0;
    m_sy   = 0;
    m_xmin = 1 << 20;
    m_xmax = -1;
    m_ymin = 1 << 20;
    m_ymax = -1;
  endtask

  task automatic m_result(output int exp_lat);
    int nv [6];
    if (m_cnt < 256) begin
      for (int i = 0; i < 6; i++) exp_out[i] = 1023;
      exp_lat = 4;
    end else begin
      nv[0] = (m_sx / m_cnt) % 1024;
      nv[1] = (m_sy / m_cnt) % 1024;
      nv[2] = m_xmin;
      nv[3] = m_xmax;
      nv[4] = m_ymin;
      nv[5] = m_ymax;
      for (int i = 0; i < 6; i++) begin
`ifdef HAND_LOCATE_SMOOTH_EN
        exp_out[i] = (exp_out[i] == 1023) ? nv[i] : (((3 * exp_out[i] + nv[i]) / 4) % 1024);
`else
        exp_out[i] = nv[i];
`endif
      end
      exp_lat = 31;
    end
  endtask

  task automatic pix(input bit v, input int x, input int y, input bit b);
    @(negedge clk);
    bus.pix_valid = v;
    bus.lcd_x     = 12'(x);
    bus.lcd_y     = 12'(y);
    bus.pix_bin   = b;
    if (v && b && x >= 100 && x <= 500 && y >= 0 && y <= 400) begin
      m_cnt++;
      m_sx += x;
      m_sy += y;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      bus.pix_bin   = 1'b0;
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_cx"},   bus.centre_x,     exp_out[0]);
    check({pfx, "_cy"},   bus.centre_y,     exp_out[1]);
    check({pfx, "_xmin"}, bus.x_min_locate, exp_out[2]);
    check({pfx, "_xmax"}, bus.x_max_locate, exp_out[3]);
    check({pfx, "_ymin"}, bus.y_min_locate, exp_out[4]);
    check({pfx, "_ymax"}, bus.y_max_locate, exp_out[5]);
  endtask

  // Raise vsync, wait (bounded) for result_valid, then check latency, outputs and pulse width.
  task automatic end_frame(input string pfx);
    int  exp_lat;
    int  lat;
    bit  seen;
    idle(2);
    @(negedge clk);
    bus.vsync = 1'b1;
    m_result(exp_lat);
    m_new_frame();
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat = i;
      if (i == 3) bus.vsync = 1'b0;
      if (bus.result_valid === 1'b1) seen = 1;
    end
    bus.vsync = 1'b0;
    check({pfx, "_seen"}, 32'(seen), 32'd1);
    check({pfx, "_latency"}, lat, exp_lat);
    check_outputs(pfx);
    $display("frame %s: latency=%0d centre=(%0d,%0d) box x %0d..%0d y %0d..%0d", pfx, lat,
             bus.centre_x, bus.centre_y, bus.x_min_locate, bus.x_max_locate,
             bus.y_min_locate, bus.y_max_locate);
    @(posedge clk);
    #1;
    check({pfx, "_pulse_end"}, 32'(bus.result_valid), 32'd0);
  endtask

  task automatic rand_frame(input int n);
    int x, y;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 9))
        0: x = 99;
        1: x = 100;
        2: x = 500;
        3: x = 501;
        default: x = $urandom_range(0, 640);
      endcase
      y = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 400 : 401)
                                      : $urandom_range(0, 480);
      pix($urandom_range(0, 9) != 0, x, y, $urandom_range(0, 4) != 0);
    end
  endtask

  initial begin
    int pulses;
    int lat;
    int exp_lat;

    bus.pix_valid = 1'b0;
    bus.lcd_x     = '0;
    bus.lcd_y     = '0;
    bus.pix_bin   = 1'b0;
    bus.vsync     = 1'b0;
    for (int i = 0; i < 6; i++) exp_out[i] = 1023;
    m_new_frame();

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_rv", 32'(bus.result_valid), 32'd0);
    check("reset_ov", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 20x20 block of hits
    for (int y = 100; y < 120; y++)
      for (int x = 200; x < 220; x++)
        pix(1, x, y, 1);
    end_frame("block");
    check("block_cx_const", bus.centre_x, 32'd209);
    check("block_cy_const", bus.centre_y, 32'd109);
    check("block_xmin_const", bus.x_min_locate, 32'd200);
    check("block_ymax_const", bus.y_max_locate, 32'd119);

    // Pixels just outside the window or without pix_valid; each class alone would exceed MIN_PIXELS
    for (int k = 0; k < 300; k++) pix(1, 99, k, 1);
    for (int k = 0; k < 300; k++) pix(1, 501, k, 1);
    for (int k = 0; k < 300; k++) pix(1, 200 + (k % 50), 401, 1);
    for (int k = 0; k < 300; k++) pix(0, 200 + (k % 50), 100 + (k / 50), 1);
    end_frame("outside");
    check("outside_cx_const", bus.centre_x, 32'd1023);

    rand_frame(1000);
    end_frame("rand1");

    // 100 hits: below the detection threshold
    for (int y = 300; y < 310; y++)
      for (int x = 300; x < 310; x++)
        pix(1, x, y, 1);
    end_frame("few");
    check("few_cy_const", bus.centre_y, 32'd1023);

    rand_frame(1000);
    end_frame("rand2");
    rand_frame(1200);
    end_frame("rand3");

    // Second vsync rise 10 cycles after the first: the first frame's divide is abandoned
    rand_frame(1000);
    idle(2);
    @(negedge clk);
    bus.vsync = 1'b1;
    m_new_frame();
    pulses = 0;
    lat    = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 3 || i == 13) bus.vsync = 1'b0;
      if (i == 10) begin
        check("ovr_before", 32'(bus.overrun), 32'd0);
        bus.vsync = 1'b1;
        m_result(exp_lat);
        m_new_frame();
      end
      if (bus.result_valid === 1'b1) begin
        pulses++;
        lat = i;
        check_outputs("ovr");
      end
    end
    $display("overrun frame: pulses=%0d latency=%0d overrun=%0d", pulses, lat, bus.overrun);
    check("ovr_pulses", pulses, 32'd1);
    check("ovr_latency", lat, 32'(10 + exp_lat));
    check("ovr_flag", 32'(bus.overrun), 32'd1);

    rand_frame(1000);
    end_frame("rand4");
    check("rand4_ov_sticky", 32'(bus.overrun), 32'd1);

    // Reset in the middle of a divide
    rand_frame(1000);
    idle(2);
    @(negedge clk);
    bus.vsync = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.vsync = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) exp_out[i] = 1023;
    m_new_frame();
    check_outputs("rstdiv");
    check("rstdiv_ov", 32'(bus.overrun), 32'd0);
    check("rstdiv_rv", 32'(bus.result_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.result_valid === 1'b1) pulses++;
    end
    $display("reset mid-divide: result pulses after release=%0d", pulses);
    check("rstdiv_no_pulse", pulses, 32'd0);

    // Two frames with centres 200 then 300 starting from the off-panel state
    idle(1);
    for (int y = 50; y < 63; y++)
      for (int x = 190; x <= 210; x++)
        pix(1, x, y, 1);
    end_frame("smoothA");
    check("smoothA_cx_const", bus.centre_x, 32'd200);
    for (int y = 50; y < 63; y++)
      for (int x = 290; x <= 310; x++)
        pix(1, x, y, 1);
    end_frame("smoothB");
`ifdef HAND_LOCATE_SMOOTH_EN
    check("smoothB_cx_const", bus.centre_x, 32'd225);
`else
    check("smoothB_cx_const", bus.centre_x, 32'd300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
